cacheline_burst_arbiter: RTL and testbench

//  Sits between the I-cache/D-cache line ports and the burst memory port of mp4.

---
 rtl/cacheline_burst_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cacheline_burst_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cacheline_burst_arbiter
//  Purpose  : Arbitrates whole-line requests from the I-cache and D-cache and
//             serialises each granted line into BEATS memory beats. Reads
//             assemble the returned beats into the line buffer; writebacks
//             slice the latched line into beats. A one-cycle resp pulse
//             closes every transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module cacheline_burst_arbiter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    // Beat counter width and the number of byte-offset bits inside one line.
    localparam int                c_cnt_w     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int                c_off_w     = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] c_addr_mask = {ADDR_W{1'b1}} << c_off_w;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_I_RD = 3'd1,
        ST_D_RD = 3'd2,
        ST_D_WR = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [LINE_W-1:0]    r_buf;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_last_d;     // 1: last grant went to the D-cache

    logic                 w_d_req;
    logic                 w_grant;
    logic                 w_grant_d;
    logic                 w_beat_ack;
    logic                 w_capture;
    logic                 w_last_beat;

    // A D-side read and write together is served as a writeback.
    assign w_d_req  = d_read | d_write;
    assign mem_addr = r_addr;
    assign i_rdata  = r_buf;
    assign d_rdata  = r_buf;

    // State register; reset drops any burst in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, grant decision and Moore-style memory/response outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_beat_ack  = 1'b0;
        w_capture   = 1'b0;
        w_last_beat = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Round-robin only matters when both sides are pending:
                // the D side loses only if it was the previous winner.
                if (w_d_req && !(i_read && r_last_d)) begin
                    w_grant     = 1'b1;
                    w_grant_d   = 1'b1;
                    w_state_nxt = d_write ? ST_D_WR : ST_D_RD;
                end else if (i_read) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_I_RD;
                end
            end
            ST_I_RD, ST_D_RD: begin
                mem_read    = 1'b1;
                w_beat_ack  = mem_resp;
                w_capture   = mem_resp;
                w_last_beat = mem_resp && (r_cnt == c_last_beat);
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_D_WR: begin
                mem_write   = 1'b1;
                mem_wdata   = r_buf[r_cnt*BEAT_W +: BEAT_W];
                w_beat_ack  = mem_resp;
                w_last_beat = mem_resp && (r_cnt == c_last_beat);
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                i_resp      = ~r_last_d;
                d_resp      = r_last_d;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant-time latching of address/line/winner, then per-beat buffer and
    // counter updates while a burst is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_buf    <= '0;
            r_addr   <= '0;
            r_last_d <= 1'b0;
        end else begin
            if (w_grant) begin
                r_addr   <= (w_grant_d ? d_addr : i_addr) & c_addr_mask;
                r_last_d <= w_grant_d;
                if (w_grant_d && d_write) begin
                    r_buf <= d_wdata;
                end
            end
            if (w_capture) begin
                r_buf[r_cnt*BEAT_W +: BEAT_W] <= mem_rdata;
            end
            if (w_beat_ack) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cacheline_burst_arbiter
//  Purpose  : Self-checking bench for cacheline_burst_arbiter. A transaction
//             level model predicts every output each cycle; directed
//             scenarios pin the model with literal expectations, followed by
//             a randomized phase with wait states and asynchronous resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_arbiter;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int PH_IDLE  = 0;
    localparam int PH_BURST = 1;
    localparam int PH_DONE  = 2;

    logic              clk;
    logic              reset;
    logic              i_read, d_read, d_write, mem_resp;
    logic              i_resp, d_resp, mem_read, mem_write;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [LINE_W-1:0] d_wdata, i_rdata, d_rdata;
    logic [BEAT_W-1:0] mem_wdata, mem_rdata;

    cacheline_burst_arbiter #(
        .BEATS (BEATS),
        .BEAT_W(BEAT_W),
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: who owns the port, which beat is next,
    // what the line holds. Outputs are derived from this each cycle.
    // ------------------------------------------------------------------
    typedef struct packed {
        int                            phase;
        int                            beat;
        logic                          last_d;
        logic                          wr;
        logic [ADDR_W-1:0]             addr;
        logic [BEATS-1:0][BEAT_W-1:0]  beats;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t s);
        model_t n;
        logic   d_req;
        logic   take_d;
        logic [ADDR_W-1:0] a;
        n = s;
        d_req = d_read | d_write;
        if (s.phase == PH_DONE) begin
            n.phase = PH_IDLE;
        end else if (s.phase == PH_BURST) begin
            if (mem_resp) begin
                if (!s.wr) n.beats[s.beat] = mem_rdata;
                if (s.beat == BEATS - 1) begin
                    n.beat  = 0;
                    n.phase = PH_DONE;
                end else begin
                    n.beat = s.beat + 1;
                end
            end
        end else if (d_req || i_read) begin
            take_d   = d_req && !(i_read && s.last_d);
            a        = take_d ? d_addr : i_addr;
            n.last_d = take_d;
            n.wr     = take_d && d_write;
            n.addr   = a - ADDR_W'(a % (LINE_W / 8));
            n.beat   = 0;
            n.phase  = PH_BURST;
            if (n.wr) n.beats = d_wdata;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_next(m);
    end

    // Single compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_burst;
            e_burst = (m.phase == PH_BURST);
            check("mem_read",  LINE_W'(mem_read),  LINE_W'(e_burst && !m.wr));
            check("mem_write", LINE_W'(mem_write), LINE_W'(e_burst && m.wr));
            check("mem_addr",  LINE_W'(mem_addr),  LINE_W'(m.addr));
            check("mem_wdata", LINE_W'(mem_wdata),
                  LINE_W'((e_burst && m.wr) ? m.beats[m.beat] : '0));
            check("i_resp",    LINE_W'(i_resp), LINE_W'(m.phase == PH_DONE && !m.last_d));
            check("d_resp",    LINE_W'(d_resp), LINE_W'(m.phase == PH_DONE && m.last_d));
            check("i_rdata",   i_rdata, m.beats);
            check("d_rdata",   d_rdata, m.beats);
            check("rd_wr_excl", LINE_W'(mem_read & mem_write), '0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [BEAT_W-1:0] pat [BEATS];
    localparam logic [LINE_W-1:0] c_pat_line =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

    function automatic logic [BEAT_W-1:0] beat_val(input logic [ADDR_W-1:0] a, input int k);
        return {a, 24'h5A5A5A, 8'(k)};
    endfunction

    function automatic logic [LINE_W-1:0] exp_line(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] r;
        for (int k = 0; k < BEATS; k++) r[k*BEAT_W +: BEAT_W] = beat_val(a, k);
        return r;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    // Asserts reset between edges and releases it on a falling edge.
    task automatic reset_dut();
        @(negedge clk);
        #2 reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int resp_cyc, beats, dresp_cnt, waitc, nresp, stage, t;
        logic [ADDR_W-1:0] addr_seen;
        logic [LINE_W-1:0] line_seen;
        logic [3:0] order;
        bit flag, bad;

        reset = 1'b1;
        clear_inputs();
        pat[0] = 64'h1111111111111111; pat[1] = 64'h2222222222222222;
        pat[2] = 64'h3333333333333333; pat[3] = 64'h4444444444444444;
        reset_dut();
        chk_en = 1'b1;

        // Reset state
        check("rst_mem_read",  LINE_W'(mem_read),  '0);
        check("rst_mem_write", LINE_W'(mem_write), '0);
        check("rst_mem_addr",  LINE_W'(mem_addr),  '0);
        check("rst_i_resp",    LINE_W'(i_resp),    '0);
        check("rst_d_resp",    LINE_W'(d_resp),    '0);
        check("rst_i_rdata",   i_rdata,            '0);

        // T1: I-read, zero-wait memory
        i_read = 1; i_addr = 32'h0000_0064; mem_resp = 1;
        resp_cyc = -1; addr_seen = '0; flag = 0; line_seen = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            mem_rdata = pat[m.beat];
            if (mem_read && n == 1) addr_seen = mem_addr;
            if (d_resp) flag = 1;
            if (i_resp) begin resp_cyc = n; line_seen = i_rdata; i_read = 0; end
        end
        check("t1_mem_addr",  LINE_W'(addr_seen), LINE_W'(32'h0000_0060));
        check("t1_resp_cyc",  LINE_W'(resp_cyc),  LINE_W'(5));
        check("t1_rdata",     line_seen,          c_pat_line);
        check("t1_no_dresp",  LINE_W'(flag),      '0);

        // T2: D-write with two wait cycles before every beat
        @(negedge clk);
        mem_resp = 0; d_write = 1; d_addr = 32'h1000_001F;
        d_wdata = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                   64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        beats = 0; dresp_cnt = 0; waitc = 0; bad = 0; addr_seen = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            d_addr = $urandom; d_wdata = rand_line();
            mem_resp = 0;
            if (mem_write) begin
                addr_seen = mem_addr;
                if (beats == 0 && mem_wdata !== 64'hAAAAAAAAAAAAAAAA) bad = 1;
                if (waitc == 2) begin mem_resp = 1; waitc = 0; beats++; end
                else waitc++;
            end
            if (d_resp) begin dresp_cnt++; d_write = 0; end
        end
        check("t2_mem_addr",   LINE_W'(addr_seen), LINE_W'(32'h1000_0000));
        check("t2_beat0_held", LINE_W'(bad),       '0);
        check("t2_beats",      LINE_W'(beats),     LINE_W'(4));
        check("t2_d_resp",     LINE_W'(dresp_cnt), LINE_W'(1));

        // T3: simultaneous I/D reads from reset alternate D,I,D,I
        reset_dut();
        i_read = 1; d_read = 1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        nresp = 0; order = '0;
        for (int n = 0; n < 200 && nresp < 4; n++) begin
            @(negedge clk);
            mem_resp = ($urandom_range(1) == 1); mem_rdata = {$urandom, $urandom};
            if (d_resp || i_resp) begin
                order[nresp] = d_resp;
                nresp++;
                if (nresp == 4) begin i_read = 0; d_read = 0; end
            end
        end
        check("t3_count", LINE_W'(nresp), LINE_W'(4));
        check("t3_order", LINE_W'(order), LINE_W'(4'b0101));

        // T4: d_read and d_write together behave as a write
        @(negedge clk);
        d_read = 1; d_write = 1; d_addr = 32'h2000_0040; d_wdata = rand_line();
        beats = 0; dresp_cnt = 0; flag = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            mem_resp = ($urandom_range(1) == 1);
            if (mem_read) flag = 1;
            if (mem_write && mem_resp) beats++;
            if (d_resp) begin dresp_cnt++; d_read = 0; d_write = 0; end
        end
        check("t4_no_mem_read", LINE_W'(flag),      '0);
        check("t4_beats",       LINE_W'(beats),     LINE_W'(4));
        check("t4_d_resp",      LINE_W'(dresp_cnt), LINE_W'(1));

        // T5: reset after beat 1 of an I-read, then a fresh burst
        @(negedge clk);
        i_read = 1; i_addr = 32'h0000_0300; mem_resp = 1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            mem_rdata = pat[m.beat];
        end
        #2 reset = 1'b0;
        #1;
        check("t5_rst_mem_read", LINE_W'(mem_read), '0);
        check("t5_rst_mem_addr", LINE_W'(mem_addr), '0);
        check("t5_rst_i_rdata",  i_rdata,           '0);
        check("t5_rst_i_resp",   LINE_W'(i_resp),   '0);
        @(negedge clk);
        reset = 1'b1;
        beats = 0; resp_cyc = -1; line_seen = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            mem_rdata = pat[m.beat];
            if (mem_read && mem_resp) beats++;
            if (i_resp) begin resp_cyc = n; line_seen = i_rdata; i_read = 0; end
        end
        check("t5_beats",    LINE_W'(beats),    LINE_W'(4));
        check("t5_resp_cyc", LINE_W'(resp_cyc), LINE_W'(5));
        check("t5_rdata",    line_seen,         c_pat_line);

        // T6: back-to-back D-reads 0x40 then 0x80
        @(negedge clk);
        d_read = 1; d_addr = 32'h0000_0040; mem_resp = 1;
        stage = 0; t = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            mem_rdata = beat_val(m.addr, m.beat);
            if (stage == 1 && n == t + 1) begin
                check("t6_idle_gap",   LINE_W'(mem_read), '0);
                check("t6_hold_rdata", d_rdata, exp_line(32'h0000_0040));
            end
            if (stage == 1 && n == t + 2) begin
                check("t6_second_read", LINE_W'(mem_read), LINE_W'(1));
                check("t6_second_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_0080));
            end
            if (d_resp && stage == 0) begin
                check("t6_line_40", d_rdata, exp_line(32'h0000_0040));
                stage = 1; t = n; d_addr = 32'h0000_0080;
            end else if (d_resp && stage == 1) begin
                check("t6_line_80", d_rdata, exp_line(32'h0000_0080));
                stage = 2; d_read = 0;
            end
        end
        check("t6_both_done", LINE_W'(stage), LINE_W'(2));

        // Randomized phase: both requesters, wait states, address/data churn
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(negedge clk);
            if ($urandom_range(499) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            if (m.phase == PH_DONE && !m.last_d) i_read = 0;
            else if (!i_read && $urandom_range(3) == 0) i_read = 1;
            if (m.phase == PH_DONE && m.last_d) begin
                d_read = 0; d_write = 0;
            end else if (!d_read && !d_write && $urandom_range(3) == 0) begin
                r = $urandom_range(2);
                d_read  = (r != 1);
                d_write = (r != 0);
            end
            i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
            mem_resp = ($urandom_range(3) != 0); mem_rdata = {$urandom, $urandom};
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
